// File: rtl/sc_sn2bn_counter_pkg.sv
// Shared definitions for the stochastic-to-binary counter: default sizing and FSM state type.
// SC_LAT must track the register depth of the CBSC_SNG -> AND -> sc_sum path.
package sc_sn2bn_counter_pkg;

  localparam int unsigned SC_WIDTH = 7;
  localparam int unsigned SC_LAT   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_ACCUM = 2'd2,
    S_DONE  = 2'd3
  } sn2bn_state_t;

  function automatic logic is_busy(input sn2bn_state_t s);
    return (s == S_ALIGN) || (s == S_ACCUM);
  endfunction

endpackage

// File: rtl/sc_sn2bn_counter.sv
// Counts the ones in one 2^WIDTH-bit SN window after skipping LAT pipeline-fill cycles,
// and holds the result behind a valid/ack handshake with a saturated WIDTH-bit copy.
module sc_sn2bn_counter
  import sc_sn2bn_counter_pkg::*;
#(
  parameter int unsigned WIDTH = SC_WIDTH,
  parameter int unsigned LAT   = SC_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic             sn_in,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH:0]   bn_out,
  output logic [WIDTH-1:0] bn_sat
);

  localparam int unsigned LW = (LAT > 0) ? $clog2(LAT + 1) : 1;

  sn2bn_state_t     state, state_d;
  logic [LW-1:0]    lat_cnt, lat_d;
  logic [WIDTH-1:0] smp_cnt, smp_d;
  logic [WIDTH:0]   ones, ones_d;
  logic [WIDTH:0]   bn_d;
  logic [WIDTH-1:0] sat_d;
  logic             valid_d;
  logic [WIDTH:0]   sum;

  assign sum = ones + {{WIDTH{1'b0}}, sn_in};

  always_comb begin
    state_d = state;
    lat_d   = lat_cnt;
    smp_d   = smp_cnt;
    ones_d  = ones;
    bn_d    = bn_out;
    valid_d = valid;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          ones_d  = '0;
          smp_d   = '0;
          lat_d   = LW'(LAT);
          state_d = (LAT > 0) ? S_ALIGN : S_ACCUM;
        end
      end
      S_ALIGN: begin
        lat_d = lat_cnt - LW'(1);
        if (lat_cnt <= LW'(1)) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        ones_d = sum;
        smp_d  = smp_cnt + WIDTH'(1);
        if (smp_cnt == '1) begin
          state_d = S_DONE;
          bn_d    = sum;
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        // ack+start restarts directly so back-to-back windows lose no cycle in IDLE
        if (ack) begin
          valid_d = 1'b0;
          if (start) begin
            ones_d  = '0;
            smp_d   = '0;
            lat_d   = LW'(LAT);
            state_d = (LAT > 0) ? S_ALIGN : S_ACCUM;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end
  end

  assign sat_d = bn_d[WIDTH] ? '1 : bn_d[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      smp_cnt <= '0;
      ones    <= '0;
      bn_out  <= '0;
      bn_sat  <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      lat_cnt <= lat_d;
      smp_cnt <= smp_d;
      ones    <= ones_d;
      bn_out  <= bn_d;
      bn_sat  <= sat_d;
      valid   <= valid_d;
      busy    <= is_busy(state_d);
    end
  end

endmodule

// File: tb/tb_sc_sn2bn_counter.sv
// Self-checking bench for sc_sn2bn_counter: edge-count model plus directed windows.
module tb_sc_sn2bn_counter;

  localparam int W   = 7;
  localparam int LAT = 3;
  localparam int N   = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic         sn_in = 1'b0;
  logic         ack = 1'b0;
  logic         busy, valid;
  logic [W:0]   bn_out;
  logic [W-1:0] bn_sat;

  sc_sn2bn_counter #(.WIDTH(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .clr(clr), .sn_in(sn_in), .ack(ack),
    .busy(busy), .valid(valid), .bn_out(bn_out), .bn_sat(bn_sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: count edges since the start edge; edges LAT+1..LAT+N contribute sn_in.
  bit m_active = 0;
  bit m_valid  = 0;
  int m_e = 0, m_sum = 0, m_bn = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 0; m_valid = 0; m_e = 0; m_sum = 0; m_bn = 0;
    end else if (clr) begin
      m_active = 0; m_valid = 0;
    end else if (m_active) begin
      m_e++;
      if (m_e > LAT) m_sum += int'(sn_in);
      if (m_e == LAT + N) begin
        m_bn = m_sum; m_valid = 1; m_active = 0;
      end
    end else if (!m_valid || ack) begin
      m_valid = 0;
      if (start) begin
        m_active = 1; m_e = 0; m_sum = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_busy", int'(busy), int'(m_active));
      chk("m_valid", int'(valid), int'(m_valid));
      chk("m_bn_out", int'(bn_out), m_bn);
      chk("m_bn_sat", int'(bn_sat), (m_bn > N - 1) ? N - 1 : m_bn);
    end
  end

  logic [6:0] lf = 7'd35;

  // pat: 0 all ones, 1 ones only during ALIGN, 2 alternating 1,0, 3 LFSR-driven
  task automatic run_window(input int pat, input bit with_ack, input bit poke, input int exp_bn);
    int ref_sum = 0;
    int busy_n = 0;
    int exp_v;
    logic b;
    @(negedge clk);
    start = 1'b1; ack = with_ack; sn_in = 1'b0;
    for (int e = 1; e <= LAT + N; e++) begin
      @(negedge clk);
      start = poke && (e == LAT + 40 || e == LAT + 90);
      ack = 1'b0;
      if (e == 1) chk("valid_after_start", int'(valid), 0);
      if (busy) busy_n++;
      if (e == LAT + N) chk("valid_early", int'(valid), 0);
      case (pat)
        0: b = 1'b1;
        1: b = (e <= LAT);
        2: b = (e <= LAT) ? 1'b1 : (((e - LAT - 1) % 2) == 0);
        default: begin
          if (e > LAT) begin
            lf = {lf[5:0], lf[6] ^ lf[5]};
            b = (lf < 7'd100);
          end else b = 1'b0;
        end
      endcase
      sn_in = b;
      if (e > LAT) ref_sum += int'(b);
    end
    @(negedge clk);
    start = 1'b0; sn_in = 1'b0;
    exp_v = (exp_bn >= 0) ? exp_bn : ref_sum;
    chk("valid_at_lat_n", int'(valid), 1);
    chk("busy_cycles", busy_n, LAT + N);
    chk("busy_end", int'(busy), 0);
    chk("result", int'(bn_out), exp_v);
    chk("result_sat", int'(bn_sat), (exp_v > N - 1) ? N - 1 : exp_v);
  endtask

  task automatic ack_pulse();
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk("ack_drop", int'(valid), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_bn_out", int'(bn_out), 0);
    chk("rst_bn_sat", int'(bn_sat), 0);
    chk_en = 1;
    rst = 1'b1;

    run_window(0, 1'b0, 1'b0, 128);
    ack_pulse();
    run_window(1, 1'b0, 1'b0, 0);
    ack_pulse();
    run_window(2, 1'b0, 1'b0, 64);

    // DONE hold with ack low; start pulses must not restart
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start = (i % 3 == 0);
      chk("hold_valid", int'(valid), 1);
      chk("hold_bn_out", int'(bn_out), 64);
    end
    @(negedge clk); start = 1'b0;
    chk("hold_busy", int'(busy), 0);

    run_window(0, 1'b1, 1'b1, 128);
    run_window(3, 1'b1, 1'b0, -1);
    ack_pulse();

    // asynchronous reset between edges mid-ACCUM
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; sn_in = 1'b1;
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_bn_out", int'(bn_out), 0);
    chk("arst_bn_sat", int'(bn_sat), 0);
    @(negedge clk); rst = 1'b1; sn_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_idle", int'(busy), 0);

    // clr mid-ACCUM keeps the previous result
    run_window(0, 1'b0, 1'b0, 128);
    ack_pulse();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("clr_busy", int'(busy), 0);
    chk("clr_valid", int'(valid), 0);
    chk("clr_bn_out", int'(bn_out), 128);
    repeat (5) @(negedge clk);
    chk("clr_stays_idle", int'(busy), 0);

    // clr in DONE beats ack+start
    run_window(2, 1'b0, 1'b0, 64);
    @(negedge clk); clr = 1'b1; ack = 1'b1; start = 1'b1;
    @(negedge clk); clr = 1'b0; ack = 1'b0; start = 1'b0;
    chk("clr_done_valid", int'(valid), 0);
    chk("clr_done_busy", int'(busy), 0);
    chk("clr_done_bn_out", int'(bn_out), 64);
    repeat (3) @(negedge clk);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
